// File: rtl/grf_scoreboard_pkg.sv
// Shared GRF geometry used by the register file, the pipeline stages and the scoreboard.
package grf_scoreboard_pkg;
  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/grf_scoreboard_sb_counter.sv
// Saturating up/down counter tracking outstanding writes to one GRF register.
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic             sat,
  output logic             zero,
  output logic [CNT_W-1:0] value
);

  logic [CNT_W-1:0] r_value;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_value <= '0;
    end else if (inc && !dec && !sat) begin
      r_value <= r_value + 1'b1;
    end else if (dec && !inc && !zero) begin
      r_value <= r_value - 1'b1;
    end
  end

  assign value = r_value;
  assign zero  = (r_value == '0);
  assign sat   = (r_value == {CNT_W{1'b1}});

endmodule

// File: rtl/grf_scoreboard.sv
// Issue-stage scoreboard: counts outstanding GRF writes per register and stalls RAW/overflow hazards.
module grf_scoreboard
  import grf_scoreboard_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  reg_addr_t           issue_rs,
  input  reg_addr_t           issue_rt,
  input  logic                issue_use_rs,
  input  logic                issue_use_rt,
  input  logic                issue_wr,
  input  reg_addr_t           issue_rd,
  output logic                issue_ready,
  input  logic                wb_valid,
  input  reg_addr_t           wb_addr,
  output logic [NUM_REGS-1:0] pending,
  output logic                idle,
  output logic                err
);

  logic [NUM_REGS-1:0] w_zero;
  logic [NUM_REGS-1:0] w_sat;
  logic [NUM_REGS-1:1] w_inc;
  logic [NUM_REGS-1:1] w_dec;
  logic [NUM_REGS-1:1] w_pend;
  logic [CNT_W-1:0]    w_cnt [1:NUM_REGS-1];
  logic                w_accept;
  logic                w_rs_haz;
  logic                w_rt_haz;
  logic                w_rd_haz;
  logic                w_wb_under;
  logic                r_err;

  // Register 0 is hardwired: never pending, never saturated.
  assign w_zero[0] = 1'b1;
  assign w_sat[0]  = 1'b0;

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_cnt
    assign w_inc[g] = w_accept && issue_wr && (issue_rd == REG_ADDR_W'(g));
    assign w_dec[g] = wb_valid && (wb_addr == REG_ADDR_W'(g));

    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (w_inc[g]),
      .dec   (w_dec[g]),
      .sat   (w_sat[g]),
      .zero  (w_zero[g]),
      .value (w_cnt[g])
    );

    assign w_pend[g] = (w_cnt[g] != '0);
  end

  // Hazards look only at registered counts; a same-cycle write-back does not unblock a reader.
  assign w_rs_haz    = issue_use_rs && (issue_rs != '0) && !w_zero[issue_rs];
  assign w_rt_haz    = issue_use_rt && (issue_rt != '0) && !w_zero[issue_rt];
  assign w_rd_haz    = issue_wr && (issue_rd != '0) && w_sat[issue_rd];
  assign issue_ready = !(w_rs_haz || w_rt_haz || w_rd_haz);
  assign w_accept    = issue_valid && issue_ready;

  // A write-back to an idle register is an error unless a new write to it is issued alongside.
  assign w_wb_under = wb_valid && (wb_addr != '0) && w_zero[wb_addr] &&
                      !(w_accept && issue_wr && (issue_rd == wb_addr));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_wb_under) begin
      r_err <= 1'b1;
    end
  end

  assign pending = {w_pend, 1'b0};
  assign idle    = (w_pend == '0);
  assign err     = r_err;

endmodule

// File: tb/tb_grf_scoreboard.sv
// Randomised and directed bench for grf_scoreboard against an array-based outstanding-write model.
module tb_grf_scoreboard;
  localparam int MAXC = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_use_rs, issue_use_rt, issue_wr, wb_valid;
  logic [4:0]  issue_rs, issue_rt, issue_rd, wb_addr;
  logic        issue_ready, idle, err;
  logic [31:0] pending;

  int n_pass  = 0;
  int n_total = 0;
  int m_cnt [32];
  bit m_err;

  grf_scoreboard #(.CNT_W(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .issue_rs     (issue_rs),
    .issue_rt     (issue_rt),
    .issue_use_rs (issue_use_rs),
    .issue_use_rt (issue_use_rt),
    .issue_wr     (issue_wr),
    .issue_rd     (issue_rd),
    .issue_ready  (issue_ready),
    .wb_valid     (wb_valid),
    .wb_addr      (wb_addr),
    .pending      (pending),
    .idle         (idle),
    .err          (err)
  );

  always #5 clk = ~clk;

  function automatic bit model_ready(bit urs, int rs, bit urt, int rt, bit wr, int rd);
    if (urs && rs != 0 && m_cnt[rs] > 0) return 1'b0;
    if (urt && rt != 0 && m_cnt[rt] > 0) return 1'b0;
    if (wr && rd != 0 && m_cnt[rd] == MAXC) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] model_pending();
    logic [31:0] p = '0;
    for (int i = 1; i < 32; i++) p[i] = (m_cnt[i] > 0);
    return p;
  endfunction

  // One clock of stimulus: check issue_ready before the edge, state after it.
  task automatic cycle(input string nm, input bit r, input bit v, input bit urs, input int rs,
                       input bit urt, input int rt, input bit wr, input int rd,
                       input bit wbv, input int wba);
    bit          exp_rdy, inc, dec;
    logic [31:0] exp_p;
    rst = r; issue_valid = v; issue_use_rs = urs; issue_rs = 5'(rs);
    issue_use_rt = urt; issue_rt = 5'(rt); issue_wr = wr; issue_rd = 5'(rd);
    wb_valid = wbv; wb_addr = 5'(wba);
    #1;
    exp_rdy = model_ready(urs, rs, urt, rt, wr, rd);
    n_total++;
    if (issue_ready !== exp_rdy)
      $display("FAIL %s ready: got %b want %b", nm, issue_ready, exp_rdy);
    else n_pass++;
    inc = v && exp_rdy && wr && rd != 0;
    dec = wbv && wba != 0;
    if (r) begin
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
      m_err = 1'b0;
    end else if (!(inc && dec && rd == wba)) begin
      if (inc) m_cnt[rd]++;
      if (dec) begin
        if (m_cnt[wba] > 0) m_cnt[wba]--;
        else m_err = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    exp_p = model_pending();
    n_total++;
    if (pending !== exp_p) $display("FAIL %s pending: got %h want %h", nm, pending, exp_p);
    else n_pass++;
    n_total++;
    if (idle !== (exp_p == 0)) $display("FAIL %s idle: got %b want %b", nm, idle, exp_p == 0);
    else n_pass++;
    n_total++;
    if (err !== m_err) $display("FAIL %s err: got %b want %b", nm, err, m_err);
    else n_pass++;
  endtask

  task automatic idle_cycle(input string nm);
    cycle(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input string nm);
    cycle(nm, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    do_reset("reset");
    n_total++;
    if (pending !== 32'h0 || idle !== 1'b1 || err !== 1'b0)
      $display("FAIL reset_state: got p=%h i=%b e=%b want p=0 i=1 e=0", pending, idle, err);
    else n_pass++;
    issue_valid = 1'b0; issue_wr = 1'b1; issue_rd = 5'd8; issue_use_rs = 1'b1; issue_rs = 5'd8;
    #1;
    n_total++;
    if (issue_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", issue_ready);
    else n_pass++;
  endtask

  task automatic test_raw_hazard();
    do_reset("raw_rst");
    cycle("raw_issue8", 0, 1, 0, 0, 0, 0, 1, 8, 0, 0);
    n_total++;
    if (pending[8] !== 1'b1 || idle !== 1'b0)
      $display("FAIL raw_pend8: got p8=%b idle=%b want p8=1 idle=0", pending[8], idle);
    else n_pass++;
    cycle("raw_stall1", 0, 1, 1, 8, 0, 0, 0, 0, 0, 0);
    cycle("raw_stall2", 0, 1, 0, 0, 1, 8, 1, 9, 0, 0);
    // Write-back and reader in the same cycle: reader still stalls this cycle.
    cycle("raw_wb_same", 0, 1, 1, 8, 0, 0, 0, 0, 1, 8);
    n_total++;
    #1;
    issue_valid = 1'b1; issue_use_rs = 1'b1; issue_rs = 5'd8; wb_valid = 1'b0;
    #1;
    if (issue_ready !== 1'b1) $display("FAIL raw_after_wb: got %b want 1", issue_ready);
    else n_pass++;
    cycle("raw_go", 0, 1, 1, 8, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_saturation();
    do_reset("sat_rst");
    for (int k = 0; k < 3; k++) cycle("sat_fill", 0, 1, 0, 0, 0, 0, 1, 5, 0, 0);
    cycle("sat_stall", 0, 1, 0, 0, 0, 0, 1, 5, 0, 0);
    n_total++;
    if (m_cnt[5] != 3 || issue_ready !== 1'b0)
      $display("FAIL sat_hold: got ready=%b want 0", issue_ready);
    else n_pass++;
    cycle("sat_wb", 0, 1, 0, 0, 0, 0, 1, 5, 1, 5);
    cycle("sat_accept", 0, 1, 0, 0, 0, 0, 1, 5, 0, 0);
    for (int k = 0; k < 3; k++) cycle("sat_drain", 0, 0, 0, 0, 0, 0, 0, 0, 1, 5);
  endtask

  task automatic test_inc_dec_same();
    do_reset("incdec_rst");
    cycle("incdec_fill", 0, 1, 0, 0, 0, 0, 1, 5, 0, 0);
    cycle("incdec_same", 0, 1, 0, 0, 0, 0, 1, 5, 1, 5);
    n_total++;
    if (pending[5] !== 1'b1 || err !== 1'b0)
      $display("FAIL incdec_keep: got p5=%b err=%b want p5=1 err=0", pending[5], err);
    else n_pass++;
    cycle("incdec_drain", 0, 0, 0, 0, 0, 0, 0, 0, 1, 5);
    // Idle register: same-cycle issue and write-back leave it pending-free with no error.
    cycle("incdec_zero", 0, 1, 0, 0, 0, 0, 1, 6, 1, 6);
  endtask

  task automatic test_err();
    do_reset("err_rst");
    cycle("err_wb12", 0, 0, 0, 0, 0, 0, 0, 0, 1, 12);
    idle_cycle("err_sticky");
    cycle("err_zero_ops", 0, 1, 0, 0, 0, 0, 1, 0, 1, 0);
    n_total++;
    if (err !== 1'b1 || pending !== 32'h0)
      $display("FAIL err_hold: got err=%b p=%h want err=1 p=0", err, pending);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset("mid_rst0");
    cycle("mid_i5", 0, 1, 0, 0, 0, 0, 1, 5, 0, 0);
    cycle("mid_i8", 0, 1, 0, 0, 0, 0, 1, 8, 0, 0);
    n_total++;
    if (pending !== 32'h0000_0120) $display("FAIL mid_pend: got %h want 00000120", pending);
    else n_pass++;
    cycle("mid_rst", 1, 1, 0, 0, 0, 0, 1, 3, 1, 12);
    n_total++;
    if (pending !== 32'h0 || idle !== 1'b1 || err !== 1'b0)
      $display("FAIL mid_clear: got p=%h i=%b e=%b want p=0 i=1 e=0", pending, idle, err);
    else n_pass++;
    cycle("mid_stale_wb", 0, 0, 0, 0, 0, 0, 0, 0, 1, 8);
  endtask

  task automatic test_random();
    do_reset("rnd_rst");
    for (int n = 0; n < 400; n++) begin
      cycle("rnd", ($urandom_range(0, 99) == 0), $urandom_range(0, 1),
            $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
            $urandom_range(0, 1), $urandom_range(0, 7),
            ($urandom_range(0, 2) == 0), $urandom_range(0, 7));
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    m_err = 1'b0;
    rst = 1'b1; issue_valid = 1'b0; issue_use_rs = 1'b0; issue_use_rt = 1'b0; issue_wr = 1'b0;
    issue_rs = '0; issue_rt = '0; issue_rd = '0; wb_valid = 1'b0; wb_addr = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_raw_hazard();
    test_saturation();
    test_inc_dec_same();
    test_err();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
